// File: rtl/pixel_fifo_pkg.sv
// -----------------------------------------------------------------------------
// pixel_fifo_pkg
// Shared video constants and helpers for the pixel FIFO slice.
//   PIXEL_WIDTH_DEFAULT : default pixel data width in bits
//   level_width()       : bits needed to count 0..depth stored pixels
// -----------------------------------------------------------------------------
package pixel_fifo_pkg;

    localparam int PIXEL_WIDTH_DEFAULT = 8;

    // A level counter must represent the full count DEPTH, hence depth+1 codes.
    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pixel_fifo_ram.sv
// -----------------------------------------------------------------------------
// pixel_fifo_ram
// Simple dual-port storage for the pixel FIFO: one write port, one registered
// read port, no reset, so it maps onto block RAM.
// Ports:
//   clk     : clock
//   wr_en   : write enable
//   wr_addr : write address
//   wr_data : write data
//   rd_addr : read address (sampled every cycle)
//   rd_data : registered read data (old contents on same-address write)
// -----------------------------------------------------------------------------
module pixel_fifo_ram
    import pixel_fifo_pkg::*;
#(
    parameter int WIDTH = PIXEL_WIDTH_DEFAULT,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Write port: store the accepted pixel.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read port, reading unconditionally every cycle.
    always_ff @(posedge clk) begin
        rd_data <= mem_r[rd_addr];
    end

endmodule

// File: rtl/pixel_fifo.sv
// -----------------------------------------------------------------------------
// pixel_fifo
// Single-clock pixel FIFO with one-cycle latency, registered head-of-queue
// output, write-through bypass and almost-full flag.
// Optional feature: define PIXEL_FIFO_WATERMARK_EN to add the `watermark`
// output holding the maximum level reached since reset (not cleared by flush).
// Ports:
//   clk          : clock, rising edge
//   reset        : synchronous reset, active low
//   flush        : synchronous discard of all stored pixels
//   in_write     : upstream offers in_pixel
//   in_pixel     : upstream pixel data
//   in_strobe    : pixel accepted this cycle
//   out_write    : out_pixel valid for downstream
//   out_pixel    : head-of-queue pixel
//   out_strobe   : downstream consumes out_pixel (only meaningful with out_write)
//   level        : number of stored pixels
//   almost_full  : level >= ALMOST_FULL
//   watermark    : (optional) maximum level since reset
// -----------------------------------------------------------------------------
module pixel_fifo
    import pixel_fifo_pkg::*;
#(
    parameter int WIDTH       = PIXEL_WIDTH_DEFAULT,
    parameter int DEPTH       = 16,
    parameter int ALMOST_FULL = DEPTH - 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          in_write,
    input  logic [WIDTH-1:0]              in_pixel,
    output logic                          in_strobe,
    output logic                          out_write,
    output logic [WIDTH-1:0]              out_pixel,
    input  logic                          out_strobe,
    output logic [level_width(DEPTH)-1:0] level,
    output logic                          almost_full
`ifdef PIXEL_FIFO_WATERMARK_EN
    ,
    output logic [level_width(DEPTH)-1:0] watermark
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = level_width(DEPTH);

    // Source of the out_pixel register contents.
    typedef enum logic [1:0] {
        SEL_ZERO = 2'd0,
        SEL_RAM  = 2'd1,
        SEL_BYP  = 2'd2
    } out_sel_e;

    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [PW-1:0]    rd_ptr_next_s;
    logic [LW-1:0]    level_r;
    logic [LW-1:0]    level_next_s;
    logic             push_s;
    logic             pop_s;
    out_sel_e         out_sel_r;
    logic [WIDTH-1:0] byp_pixel_r;
    logic [WIDTH-1:0] ram_q_s;

    // Accepted push/pop for this cycle; reset and flush suppress both.
    always_comb begin
        push_s = 1'b0;
        pop_s  = 1'b0;
        if (reset && !flush) begin
            push_s = in_write && (level_r != LW'(DEPTH));
            pop_s  = out_strobe && (level_r != {LW{1'b0}});
        end else begin
            push_s = 1'b0;
            pop_s  = 1'b0;
        end
    end

    // Read pointer after this edge; also the RAM read address, so the RAM
    // output register always holds the entry that will be the head.
    always_comb begin
        rd_ptr_next_s = rd_ptr_r;
        if (!reset || flush) begin
            rd_ptr_next_s = {PW{1'b0}};
        end else if (pop_s) begin
            rd_ptr_next_s = rd_ptr_r + PW'(1'b1);
        end else begin
            rd_ptr_next_s = rd_ptr_r;
        end
    end

    // Level after this edge; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        level_next_s = level_r;
        case ({push_s, pop_s})
            2'b10:   level_next_s = level_r + LW'(1'b1);
            2'b01:   level_next_s = level_r - LW'(1'b1);
            default: level_next_s = level_r;
        endcase
    end

    pixel_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (push_s),
        .wr_addr (wr_ptr_r),
        .wr_data (in_pixel),
        .rd_addr (rd_ptr_next_s),
        .rd_data (ram_q_s)
    );

    // Pointer, level and output-source state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_r  <= {PW{1'b0}};
            rd_ptr_r  <= {PW{1'b0}};
            level_r   <= {LW{1'b0}};
            out_sel_r <= SEL_ZERO;
        end else if (flush) begin
            wr_ptr_r  <= {PW{1'b0}};
            rd_ptr_r  <= {PW{1'b0}};
            level_r   <= {LW{1'b0}};
            out_sel_r <= SEL_RAM;
        end else begin
            wr_ptr_r <= push_s ? (wr_ptr_r + PW'(1'b1)) : wr_ptr_r;
            rd_ptr_r <= rd_ptr_next_s;
            level_r  <= level_next_s;
            // The RAM read of an address being written this edge returns old
            // data, so the new head comes from the bypass register instead.
            if (push_s && (rd_ptr_next_s == wr_ptr_r)) begin
                out_sel_r <= SEL_BYP;
            end else begin
                out_sel_r <= SEL_RAM;
            end
        end
    end

    // Bypass copy of the incoming pixel; only selected when it is the new head.
    always_ff @(posedge clk) begin
        byp_pixel_r <= in_pixel;
    end

    // Head-of-queue pixel: one of the two registers, or zero after reset.
    always_comb begin
        out_pixel = {WIDTH{1'b0}};
        case (out_sel_r)
            SEL_RAM:  out_pixel = ram_q_s;
            SEL_BYP:  out_pixel = byp_pixel_r;
            default:  out_pixel = {WIDTH{1'b0}};
        endcase
    end

    assign in_strobe   = push_s;
    assign out_write   = reset && !flush && (level_r != {LW{1'b0}});
    assign level       = level_r;
    assign almost_full = reset && (level_r >= LW'(ALMOST_FULL));

`ifdef PIXEL_FIFO_WATERMARK_EN
    logic [LW-1:0] watermark_r;

    // Peak level since reset; flush leaves it untouched.
    always_ff @(posedge clk) begin
        if (!reset) begin
            watermark_r <= {LW{1'b0}};
        end else if (level_next_s > watermark_r) begin
            watermark_r <= level_next_s;
        end else begin
            watermark_r <= watermark_r;
        end
    end

    assign watermark = watermark_r;
`endif

endmodule

// File: tb/tb_pixel_fifo.sv
// -----------------------------------------------------------------------------
// tb_pixel_fifo
// Directed bench for pixel_fifo (WIDTH=8, DEPTH=16). Stimulus pushes expected
// pixels into a scoreboard queue when they should be accepted; a negedge
// monitor pops and compares whenever a pixel is consumed.
// -----------------------------------------------------------------------------
module tb_pixel_fifo;
    import pixel_fifo_pkg::*;

    localparam int LW = level_width(16);

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_write;
    logic [7:0]    in_pixel;
    logic          in_strobe;
    logic          out_write;
    logic [7:0]    out_pixel;
    logic          out_strobe;
    logic [LW-1:0] level;
    logic          almost_full;
`ifdef PIXEL_FIFO_WATERMARK_EN
    logic [LW-1:0] watermark;
`endif

    int         total = 0;
    int         bad   = 0;
    int         mlev  = 0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    pixel_fifo #(.WIDTH(8), .DEPTH(16), .ALMOST_FULL(14)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_write    (in_write),
        .in_pixel    (in_pixel),
        .in_strobe   (in_strobe),
        .out_write   (out_write),
        .out_pixel   (out_pixel),
        .out_strobe  (out_strobe),
        .level       (level),
        .almost_full (almost_full)
`ifdef PIXEL_FIFO_WATERMARK_EN
        ,
        .watermark   (watermark)
`endif
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Consumption monitor: the popped pixel must be the oldest expected one.
    always @(negedge clk) begin
        logic [7:0] e;
        if (out_write && out_strobe) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL out_pixel_order: got 0x%0h expected none (queue empty)", out_pixel);
            end else begin
                e = sb.pop_front();
                chk("out_pixel_order", out_pixel, e);
            end
        end
    end

    // One clock cycle: drive, check acceptance at negedge, update the model,
    // pass the edge, then return inputs to idle for post-edge checks.
    task automatic step(input bit w, input logic [7:0] p, input bit r, input bit f, input bit rs);
        bit exp_acc;
        bit exp_pop;
        in_write   = w;
        in_pixel   = p;
        out_strobe = r;
        flush      = f;
        reset      = rs;
        @(negedge clk);
        exp_acc = w && (mlev < 16) && rs && !f;
        exp_pop = r && (mlev != 0) && rs && !f;
        chk("in_strobe", in_strobe, exp_acc);
        chk("out_write_pre", out_write, (mlev != 0) && rs && !f);
        if (!rs || f) begin
            sb.delete();
            mlev = 0;
        end else begin
            if (exp_acc) sb.push_back(p);
            mlev = mlev + int'(exp_acc) - int'(exp_pop);
        end
        @(posedge clk);
        #1;
        in_write   = 1'b0;
        out_strobe = 1'b0;
        flush      = 1'b0;
        reset      = 1'b1;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; flush = 1'b0; in_write = 1'b0; out_strobe = 1'b0; in_pixel = 8'h00;
        @(posedge clk);
        #1;

        // Reset state
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
        chk("rst_level", level, 0);
        chk("rst_out_write", out_write, 0);
        chk("rst_out_pixel", out_pixel, 8'h00);
        chk("rst_almost_full", almost_full, 0);
`ifdef PIXEL_FIFO_WATERMARK_EN
        chk("rst_watermark", watermark, 0);
`endif

        // First push after reset: visible one cycle later
        step(1'b1, 8'h11, 1'b0, 1'b0, 1'b1);
        chk("lat_out_write", out_write, 1);
        chk("lat_out_pixel", out_pixel, 8'h11);
        chk("lat_level", level, 1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        chk("pop_level", level, 0);

        // out_strobe while empty must be ignored
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        chk("empty_pop_level", level, 0);

        // Fill to 16, almost_full from 14
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b1);
            chk("fill_level", level, i + 1);
            chk("fill_almost_full", almost_full, int'((i + 1) >= 14));
        end
        chk("full_head", out_pixel, 8'h20);
        step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
        chk("full_level", level, 16);

        // Push+pop from full for 40 cycles: at full the push is refused, so
        // the first cycle drains one and the FIFO then sits at 15.
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 8'(8'h40 + i), 1'b1, 1'b0, 1'b1);
            chk("stream_level", level, 15);
        end
        for (int i = 0; i < 15; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        end
        chk("drain_level", level, 0);
        chk("drain_out_write", out_write, 0);

        // Bypass at level 1
        step(1'b1, 8'h77, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'hA5, 1'b1, 1'b0, 1'b1);
        chk("bypass_out_pixel", out_pixel, 8'hA5);
        chk("bypass_level", level, 1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

        // Flush at level 9 after a fresh reset
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b1);
        end
        chk("preflush_level", level, 9);
        step(1'b1, 8'h99, 1'b1, 1'b1, 1'b1);
        chk("flush_level", level, 0);
        chk("flush_out_write", out_write, 0);
`ifdef PIXEL_FIFO_WATERMARK_EN
        chk("flush_watermark", watermark, 9);
`endif

        // Reset during a push at level 5
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'(8'h50 + i), 1'b0, 1'b0, 1'b1);
        end
        step(1'b1, 8'hBB, 1'b0, 1'b0, 1'b0);
        chk("midrst_level", level, 0);
        chk("midrst_out_write", out_write, 0);
        chk("midrst_out_pixel", out_pixel, 8'h00);
        chk("midrst_almost_full", almost_full, 0);
        step(1'b1, 8'hCC, 1'b0, 1'b0, 1'b1);
        chk("postrst_out_pixel", out_pixel, 8'hCC);
        chk("postrst_level", level, 1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
